alu_operand_stage: RTL and testbench

//  Execute-entry pipeline register placed directly upstream of the arithmetic/logic unit.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_op_decode.sv | 66 ++++++
 rtl/alu_operand_stage.sv | 192 +++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared encodings for the ALU operand stage and the ALU behind it:
//   - arth_out_sel result-select codes (SEL_*)
//   - shift_op codes (SHIFT_*)
//   - RV32 OP/OP-IMM funct3 values (F3_*)
//   - dec_t: control bundle produced by alu_op_decode
// ---------------------------------------------------------------------------
package alu_pkg;

    // Result select seen by the ALU output mux
    localparam logic [2:0] SEL_XOR  = 3'b000;
    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_SLT  = 3'b010;
    localparam logic [2:0] SEL_SLTU = 3'b011;
    localparam logic [2:0] SEL_AND  = 3'b100;
    localparam logic [2:0] SEL_OR   = 3'b101;
    localparam logic [2:0] SEL_PASS = 3'b110;

    // Shifter operation
    localparam logic [1:0] SHIFT_NONE = 2'b00;
    localparam logic [1:0] SHIFT_SLL  = 2'b01;
    localparam logic [1:0] SHIFT_SRL  = 2'b10;
    localparam logic [1:0] SHIFT_SRA  = 2'b11;

    // RV32 funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Decoded unit controls
    typedef struct packed {
        logic [2:0] sel;
        logic       negate;
        logic       inv_rhs;
        logic [1:0] shift_op;
        logic       sext;      // replicate operand MSB into the two extension bits
    } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Purely combinational decode of an RV32 ALU op into the unit controls.
// Ports:
//   funct3  in  3   RV32 funct3
//   alt     in  1   funct7[5] (SUB / SRA)
//   use_imm in  1   rhs comes from the immediate
//   dec     out     dec_t control bundle (sel, negate, inv_rhs, shift_op, sext)
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alt,
    input  logic       use_imm,
    output dec_t       dec
);

    // funct3/alt/use_imm -> unit controls
    always_comb begin
        dec.sel      = SEL_XOR;
        dec.negate   = 1'b0;
        dec.inv_rhs  = 1'b0;
        dec.shift_op = SHIFT_NONE;
        dec.sext     = 1'b0;
        case (funct3)
            F3_ADD: begin
                dec.sel    = SEL_ADD;
                // ADDI has no SUB form; imm[10] must not turn it into a subtract
                dec.negate = alt & ~use_imm;
            end
            F3_SLT: begin
                dec.sel    = SEL_SLT;
                dec.negate = 1'b1;
                dec.sext   = 1'b1;
            end
            F3_SLTU: begin
                dec.sel    = SEL_SLTU;
                dec.negate = 1'b1;
            end
            F3_XOR: begin
                dec.sel = SEL_XOR;
            end
            F3_OR: begin
                dec.sel = SEL_OR;
            end
            F3_AND: begin
                dec.sel     = SEL_AND;
                dec.inv_rhs = 1'b0;
            end
            F3_SLL: begin
                dec.sel      = SEL_PASS;
                dec.shift_op = SHIFT_SLL;
            end
            F3_SR: begin
                dec.sel      = SEL_PASS;
                dec.shift_op = alt ? SHIFT_SRA : SHIFT_SRL;
            end
            default: begin
                dec.sel      = SEL_XOR;
                dec.shift_op = SHIFT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Execute-entry pipeline register in front of the ALU. Takes a decoded RV32
// ALU op over valid/ready, selects and extends the operands to W+2 bits,
// decodes the unit controls and presents everything from registers.
//
// Configuration macro: ALU_OPSTAGE_FWD_EN
//   defined   -> rs1_addr, rs2_addr, fwd_valid, fwd_rd, fwd_data ports exist and
//                a matching non-zero fwd_rd replaces rsN_data (never imm)
//   undefined -> operands pass unmodified
//
// Ports:
//   clk, rst_n           clock (rising), async active-low reset
//   flush                synchronous kill of the held op (wins over capture)
//   in_valid / in_ready  upstream handshake; in_ready = !out_valid | out_ready
//   rs1_data, rs2_data   register operands (W)
//   imm, use_imm         immediate and rhs select
//   funct3, alt          op encoding
//   out_valid/out_ready  downstream handshake
//   in_lhs, in_rhs       extended operands (W+2)
//   inv_rhs, negate      adder / AND-path controls
//   arth_out_sel         result select
//   shift_op, shamt      shifter controls (shamt = rhs[4:0] for shifts, else 0)
// ---------------------------------------------------------------------------
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int W    = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    rs1_data,
    input  logic [W-1:0]    rs2_data,
    input  logic [W-1:0]    imm,
    input  logic            use_imm,
    input  logic [2:0]      funct3,
    input  logic            alt,
`ifdef ALU_OPSTAGE_FWD_EN
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    input  logic            fwd_valid,
    input  logic [RA_W-1:0] fwd_rd,
    input  logic [W-1:0]    fwd_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W+1:0]    in_lhs,
    output logic [W+1:0]    in_rhs,
    output logic            inv_rhs,
    output logic            negate,
    output logic [2:0]      arth_out_sel,
    output logic [1:0]      shift_op,
    output logic [4:0]      shamt
);

    dec_t           dec_s;
    logic [W-1:0]   rs1_eff_s;
    logic [W-1:0]   rs2_eff_s;
    logic [W-1:0]   rhs_s;
    logic [W+1:0]   lhs_ext_s;
    logic [W+1:0]   rhs_ext_s;
    logic           in_ready_s;
    logic           take_s;

    logic           out_valid_d, out_valid_q;
    logic [W+1:0]   lhs_d, lhs_q;
    logic [W+1:0]   rhs_d, rhs_q;
    logic           inv_rhs_d, inv_rhs_q;
    logic           negate_d, negate_q;
    logic [2:0]     sel_d, sel_q;
    logic [1:0]     shift_op_d, shift_op_q;
    logic [4:0]     shamt_d, shamt_q;

    alu_op_decode u_dec (
        .funct3  (funct3),
        .alt     (alt),
        .use_imm (use_imm),
        .dec     (dec_s)
    );

`ifdef ALU_OPSTAGE_FWD_EN
    // Bypass: x0 is never forwarded
    always_comb begin
        rs1_eff_s = rs1_data;
        rs2_eff_s = rs2_data;
        if (fwd_valid && (fwd_rd != {RA_W{1'b0}}) && (fwd_rd == rs1_addr)) begin
            rs1_eff_s = fwd_data;
        end else begin
            rs1_eff_s = rs1_data;
        end
        if (fwd_valid && (fwd_rd != {RA_W{1'b0}}) && (fwd_rd == rs2_addr)) begin
            rs2_eff_s = fwd_data;
        end else begin
            rs2_eff_s = rs2_data;
        end
    end
`else
    // RA_W only sizes the forwarding ports; keep it referenced in this build
    logic [RA_W-1:0] unused_ra_w_s;
    assign unused_ra_w_s = {RA_W{1'b0}};

    // No bypass in this build
    always_comb begin
        rs1_eff_s = rs1_data;
        rs2_eff_s = rs2_data;
    end
`endif

    // Operand select and extension; zero extension exposes the unsigned borrow at bit W
    always_comb begin
        rhs_s = use_imm ? imm : rs2_eff_s;
        if (dec_s.sext) begin
            lhs_ext_s = {{2{rs1_eff_s[W-1]}}, rs1_eff_s};
            rhs_ext_s = {{2{rhs_s[W-1]}}, rhs_s};
        end else begin
            lhs_ext_s = {2'b00, rs1_eff_s};
            rhs_ext_s = {2'b00, rhs_s};
        end
    end

    // Handshake: the single register frees up in the same cycle it is consumed
    always_comb begin
        in_ready_s = ~out_valid_q | out_ready;
        take_s     = in_valid & in_ready_s;
    end

    // Next-state of the stage register; flush beats capture
    always_comb begin
        out_valid_d = out_valid_q;
        lhs_d       = lhs_q;
        rhs_d       = rhs_q;
        inv_rhs_d   = inv_rhs_q;
        negate_d    = negate_q;
        sel_d       = sel_q;
        shift_op_d  = shift_op_q;
        shamt_d     = shamt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (take_s) begin
            out_valid_d = 1'b1;
            lhs_d       = lhs_ext_s;
            rhs_d       = rhs_ext_s;
            inv_rhs_d   = dec_s.inv_rhs;
            negate_d    = dec_s.negate;
            sel_d       = dec_s.sel;
            shift_op_d  = dec_s.shift_op;
            shamt_d     = (dec_s.shift_op != SHIFT_NONE) ? rhs_s[4:0] : 5'd0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            lhs_q       <= {(W+2){1'b0}};
            rhs_q       <= {(W+2){1'b0}};
            inv_rhs_q   <= 1'b0;
            negate_q    <= 1'b0;
            sel_q       <= 3'b000;
            shift_op_q  <= 2'b00;
            shamt_q     <= 5'd0;
        end else begin
            out_valid_q <= out_valid_d;
            lhs_q       <= lhs_d;
            rhs_q       <= rhs_d;
            inv_rhs_q   <= inv_rhs_d;
            negate_q    <= negate_d;
            sel_q       <= sel_d;
            shift_op_q  <= shift_op_d;
            shamt_q     <= shamt_d;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_q;
    assign in_lhs       = lhs_q;
    assign in_rhs       = rhs_q;
    assign inv_rhs      = inv_rhs_q;
    assign negate       = negate_q;
    assign arth_out_sel = sel_q;
    assign shift_op     = shift_op_q;
    assign shamt        = shamt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed bench for alu_operand_stage with hand-computed expected values.
// Forwarding checks are compiled in when ALU_OPSTAGE_FWD_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

    localparam int W    = 32;
    localparam int RA_W = 5;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    rs1_data;
    logic [W-1:0]    rs2_data;
    logic [W-1:0]    imm;
    logic            use_imm;
    logic [2:0]      funct3;
    logic            alt;
    logic            out_valid;
    logic            out_ready;
    logic [W+1:0]    in_lhs;
    logic [W+1:0]    in_rhs;
    logic            inv_rhs;
    logic            negate;
    logic [2:0]      arth_out_sel;
    logic [1:0]      shift_op;
    logic [4:0]      shamt;
`ifdef ALU_OPSTAGE_FWD_EN
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic            fwd_valid;
    logic [RA_W-1:0] fwd_rd;
    logic [W-1:0]    fwd_data;
`endif

    int errors;
    int checks;

    alu_operand_stage #(.W(W), .RA_W(RA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .use_imm      (use_imm),
        .funct3       (funct3),
        .alt          (alt),
`ifdef ALU_OPSTAGE_FWD_EN
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .in_lhs       (in_lhs),
        .in_rhs       (in_rhs),
        .inv_rhs      (inv_rhs),
        .negate       (negate),
        .arth_out_sel (arth_out_sel),
        .shift_op     (shift_op),
        .shamt        (shamt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                          input logic ui, input logic [2:0] f3, input logic a);
        rs1_data = r1;
        rs2_data = r2;
        imm      = im;
        use_imm  = ui;
        funct3   = f3;
        alt      = a;
    endtask

    // One clock, sampling 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one cycle with out_ready high, then drop in_valid
    task automatic issue(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic ui, input logic [2:0] f3, input logic a);
        set_op(r1, r2, im, ui, f3, a);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_op(32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0);
`ifdef ALU_OPSTAGE_FWD_EN
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
        fwd_valid = 1'b0;
        fwd_rd    = 5'd0;
        fwd_data  = 32'h0;
`endif
        #2 rst_n = 1'b0;
        tick();
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_lhs", {30'd0, in_lhs}, 64'd0);
        check("reset_sel", {61'd0, arth_out_sel}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // SUB 5 - 7
        issue(32'd5, 32'd7, 32'd0, 1'b0, 3'b000, 1'b1);
        check("sub_valid", {63'd0, out_valid}, 64'd1);
        check("sub_negate", {63'd0, negate}, 64'd1);
        check("sub_sel", {61'd0, arth_out_sel}, 64'd1);
        check("sub_lhs", {30'd0, in_lhs}, 64'h5);
        check("sub_rhs", {30'd0, in_rhs}, 64'h7);
        check("sub_shift_op", {62'd0, shift_op}, 64'd0);

        // SLT sign-extends both operands
        issue(32'h8000_0000, 32'h0000_0001, 32'd0, 1'b0, 3'b010, 1'b0);
        check("slt_lhs", {30'd0, in_lhs}, 64'h3_8000_0000);
        check("slt_rhs", {30'd0, in_rhs}, 64'h0_0000_0001);
        check("slt_sel", {61'd0, arth_out_sel}, 64'd2);
        check("slt_negate", {63'd0, negate}, 64'd1);

        // SLTU zero-extends
        issue(32'h8000_0000, 32'h8000_0001, 32'd0, 1'b0, 3'b011, 1'b0);
        check("sltu_lhs", {30'd0, in_lhs}, 64'h0_8000_0000);
        check("sltu_rhs", {30'd0, in_rhs}, 64'h0_8000_0001);
        check("sltu_sel", {61'd0, arth_out_sel}, 64'd3);

        // ADDI with imm bit 10 set: alt must not cause a subtract
        issue(32'd3, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 3'b000, 1'b1);
        check("addi_negate", {63'd0, negate}, 64'd0);
        check("addi_rhs", {30'd0, in_rhs}, 64'h0_FFFF_FFFF);
        check("addi_sel", {61'd0, arth_out_sel}, 64'd1);

        // SRAI shamt 5
        issue(32'hF000_0000, 32'd0, 32'h0000_0405, 1'b1, 3'b101, 1'b1);
        check("srai_shift_op", {62'd0, shift_op}, 64'd3);
        check("srai_shamt", {59'd0, shamt}, 64'd5);
        check("srai_sel", {61'd0, arth_out_sel}, 64'd6);

        // SRL register, shamt from rs2
        issue(32'hF000_0000, 32'h0000_0027, 32'd0, 1'b0, 3'b101, 1'b0);
        check("srl_shift_op", {62'd0, shift_op}, 64'd2);
        check("srl_shamt", {59'd0, shamt}, 64'd7);

        // SLL register
        issue(32'd1, 32'h0000_0023, 32'd0, 1'b0, 3'b001, 1'b0);
        check("sll_shift_op", {62'd0, shift_op}, 64'd1);
        check("sll_shamt", {59'd0, shamt}, 64'd3);

        // Logic ops
        issue(32'hAAAA_5555, 32'h0F0F_0F0F, 32'd0, 1'b0, 3'b111, 1'b0);
        check("and_sel", {61'd0, arth_out_sel}, 64'd4);
        check("and_inv_rhs", {63'd0, inv_rhs}, 64'd0);
        check("and_shift_op", {62'd0, shift_op}, 64'd0);
        check("and_shamt", {59'd0, shamt}, 64'd0);
        issue(32'd1, 32'd2, 32'd0, 1'b0, 3'b110, 1'b0);
        check("or_sel", {61'd0, arth_out_sel}, 64'd5);
        issue(32'd1, 32'd2, 32'd0, 1'b0, 3'b100, 1'b0);
        check("xor_sel", {61'd0, arth_out_sel}, 64'd0);
        check("xor_negate", {63'd0, negate}, 64'd0);

        // Idle cycle drains the stage
        tick();
        check("drain_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: three ops while out_ready=0
        out_ready = 1'b0;
        set_op(32'd1, 32'd10, 32'd0, 1'b0, 3'b000, 1'b0);
        in_valid = 1'b1;
        tick();
        check("bp_op1_valid", {63'd0, out_valid}, 64'd1);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        set_op(32'd2, 32'd20, 32'd0, 1'b0, 3'b000, 1'b0);
        tick();
        check("bp_op1_hold_lhs", {30'd0, in_lhs}, 64'd1);
        tick();
        check("bp_op1_hold_rhs", {30'd0, in_rhs}, 64'd10);
        check("bp_op1_hold_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", {63'd0, in_ready}, 64'd1);
        tick();
        check("bp_op2_lhs", {30'd0, in_lhs}, 64'd2);
        set_op(32'd3, 32'd30, 32'd0, 1'b0, 3'b000, 1'b0);
        tick();
        check("bp_op3_lhs", {30'd0, in_lhs}, 64'd3);
        check("bp_op3_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // Flush with a held op and a new ADDI offered in the same cycle
        out_ready = 1'b0;
        issue(32'd4, 32'd0, 32'd0, 1'b0, 3'b000, 1'b0);
        check("flush_pre_valid", {63'd0, out_valid}, 64'd1);
        set_op(32'd8, 32'd0, 32'd1, 1'b1, 3'b000, 1'b0);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check("flush_no_emit", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;

        // Asynchronous reset while an op is held
        out_ready = 1'b0;
        issue(32'h55, 32'h66, 32'd0, 1'b0, 3'b000, 1'b1);
        check("areset_pre_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_valid", {63'd0, out_valid}, 64'd0);
        check("areset_lhs", {30'd0, in_lhs}, 64'd0);
        check("areset_rhs", {30'd0, in_rhs}, 64'd0);
        check("areset_negate", {63'd0, negate}, 64'd0);
        check("areset_sel", {61'd0, arth_out_sel}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("areset_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        tick();

`ifdef ALU_OPSTAGE_FWD_EN
        // Forwarding replaces rs1 on address match
        fwd_valid = 1'b1;
        fwd_rd    = 5'd3;
        fwd_data  = 32'd9;
        rs1_addr  = 5'd3;
        rs2_addr  = 5'd4;
        issue(32'd1, 32'd2, 32'd0, 1'b0, 3'b000, 1'b0);
        check("fwd_lhs", {30'd0, in_lhs}, 64'd9);
        check("fwd_rhs_nomatch", {30'd0, in_rhs}, 64'd2);
        // Immediate is never replaced
        rs2_addr = 5'd3;
        issue(32'd1, 32'd2, 32'd7, 1'b1, 3'b000, 1'b0);
        check("fwd_imm_kept", {30'd0, in_rhs}, 64'd7);
        // x0 is never forwarded
        fwd_rd   = 5'd0;
        rs1_addr = 5'd0;
        issue(32'd1, 32'd2, 32'd0, 1'b0, 3'b000, 1'b0);
        check("fwd_x0_lhs", {30'd0, in_lhs}, 64'd1);
        fwd_valid = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
